lenet_result_streamer: RTL

//  Consumer end of the accelerator's result interface: snapshots the parallel NUM_CLASSES-entry

---
 rtl/lenet_pkg.sv | 14 +
 rtl/lenet_argmax_tracker.sv | 46 ++++
 rtl/lenet_result_streamer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lenet_pkg.sv
// Shared definitions for the LeNet accelerator result path.
// Holds the result streamer FSM encoding and the default vector geometry.
package lenet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } result_state_t;

    localparam int LENET_BITWIDTH    = 32;
    localparam int LENET_NUM_CLASSES = 10;

endpackage : lenet_pkg

// File: rtl/lenet_argmax_tracker.sv
// Running signed argmax over the beats of one result vector.
// Built only when LENET_RESULT_ARGMAX_EN is defined.
// The beat with index 0 always seeds the running best. Later beats replace it
// only on a strictly greater score, so ties keep the lower index.
`ifdef LENET_RESULT_ARGMAX_EN
module lenet_argmax_tracker
    import lenet_pkg::*;
#(
    parameter int BITWIDTH = LENET_BITWIDTH,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_beat_valid,
    input  logic [BITWIDTH-1:0] i_word,
    input  logic [IDX_W-1:0]    i_idx,
    output logic [IDX_W-1:0]    o_best_idx
);

    logic signed [BITWIDTH-1:0] r_bestVal;
    logic        [IDX_W-1:0]    r_bestIdx;
    logic                       w_takeBeat;

    // A beat wins if it starts a new vector or beats the current best.
    always_comb begin
        w_takeBeat = 1'b0;
        if (i_beat_valid) begin
            w_takeBeat = (i_idx == '0) || ($signed(i_word) > r_bestVal);
        end
    end

    // Hold the best score seen so far and where it was found.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bestVal <= '0;
            r_bestIdx <= '0;
        end else if (w_takeBeat) begin
            r_bestVal <= $signed(i_word);
            r_bestIdx <= i_idx;
        end
    end

    assign o_best_idx = r_bestIdx;

endmodule : lenet_argmax_tracker
`endif

// File: rtl/lenet_result_streamer.sv
// Result streamer: snapshots the accelerator's parallel score vector and
// plays it out one word per valid/ready beat, then pulses class_valid.
// Optional feature macro: LENET_RESULT_ARGMAX_EN (adds argmax class index).
module lenet_result_streamer
    import lenet_pkg::*;
#(
    parameter  int BITWIDTH    = LENET_BITWIDTH,
    parameter  int NUM_CLASSES = LENET_NUM_CLASSES,
    localparam int IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [BITWIDTH-1:0] i_in_vector [NUM_CLASSES-1:0],
    output logic                o_busy,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [BITWIDTH-1:0] o_out_data,
    output logic [IDX_W-1:0]    o_out_idx,
    output logic                o_out_last,
    output logic                o_class_valid,
    output logic [IDX_W-1:0]    o_class_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    result_state_t       r_state;
    logic [BITWIDTH-1:0] r_snap [NUM_CLASSES-1:0];
    logic [IDX_W-1:0]    r_beatIdx;
    logic                w_streaming;
    logic                w_isLast;
    logic                w_beatFire;
    logic                w_capture;

    assign w_streaming = (r_state == ST_STREAM);
    assign w_isLast    = (r_beatIdx == LAST_IDX);
    assign w_beatFire  = w_streaming & i_out_ready;
    assign w_capture   = (r_state == ST_IDLE) & i_start;

    // Sequence IDLE -> STREAM -> DONE -> IDLE; start outside IDLE is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_beatIdx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_beatIdx <= '0;
                        r_state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (i_out_ready) begin
                        if (w_isLast) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_beatIdx <= r_beatIdx + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Freeze the whole score vector at start so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                r_snap[i] <= i_in_vector[i];
            end
        end
    end

    // Beat outputs are derived from registered state, so they sit still under back-pressure.
    always_comb begin
        o_out_valid = w_streaming;
        o_out_data  = '0;
        o_out_idx   = '0;
        o_out_last  = 1'b0;
        if (w_streaming) begin
            o_out_data = r_snap[r_beatIdx];
            o_out_idx  = r_beatIdx;
            o_out_last = w_isLast;
        end
    end

    assign o_busy        = (r_state != ST_IDLE);
    assign o_class_valid = (r_state == ST_DONE);

`ifdef LENET_RESULT_ARGMAX_EN
    logic [IDX_W-1:0] w_bestIdx;
    logic [IDX_W-1:0] r_classIdx;

    lenet_argmax_tracker #(
        .BITWIDTH (BITWIDTH),
        .IDX_W    (IDX_W)
    ) u_argmax (
        .clk          (clk),
        .rst          (rst),
        .i_beat_valid (w_beatFire),
        .i_word       (o_out_data),
        .i_idx        (r_beatIdx),
        .o_best_idx   (w_bestIdx)
    );

    // Latch the winner in DONE so class_idx holds until the next vector finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_classIdx <= '0;
        end else if (r_state == ST_DONE) begin
            r_classIdx <= w_bestIdx;
        end
    end

    assign o_class_idx = (r_state == ST_DONE) ? w_bestIdx : r_classIdx;
`else
    logic w_unusedFire;
    assign w_unusedFire = w_beatFire;
    assign o_class_idx  = '0;
`endif

endmodule : lenet_result_streamer
